// File: rtl/fb_line_prefetch_arbiter.sv
// Single-port framebuffer RAM arbiter: capture writes share the port with a beam-scheduled
// line prefetcher that copies the next source line into a ping-pong line buffer.
module fb_line_prefetch_arbiter #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned ADDR_W     = 15,
  parameter int unsigned SRC_W      = 32,
  parameter int unsigned SRC_H      = 342,
  parameter int          V_OFF      = 69,
  parameter int          PREFETCH_X = -150,
  parameter int unsigned FB_BASE    = 0
) (
  input  logic                   i_pix_clk,
  input  logic                   i_rst,
  input  logic signed [15:0]     i_sx,
  input  logic signed [15:0]     i_sy,
  input  logic                   i_frame,
  input  logic                   i_wr_req,
  input  logic [ADDR_W-1:0]      i_wr_addr,
  input  logic [DATA_W-1:0]      i_wr_data,
  output logic                   o_wr_ack,
  output logic                   o_ram_en,
  output logic                   o_ram_we,
  output logic [ADDR_W-1:0]      o_ram_addr,
  output logic [DATA_W-1:0]      o_ram_wdata,
  input  logic [DATA_W-1:0]      i_ram_rdata,
  output logic                   o_lb_we,
  output logic [$clog2(SRC_W):0] o_lb_addr,
  output logic [DATA_W-1:0]      o_lb_data,
  output logic                   o_disp_bank,
  output logic                   o_disp_valid,
  output logic                   o_underrun
);

  localparam int unsigned WW = $clog2(SRC_W);
  localparam logic signed [16:0] LINE_LO    = 17'(V_OFF);
  localparam logic signed [16:0] LINE_HI    = 17'(V_OFF + int'(SRC_H));
  localparam logic signed [15:0] TRIG_X     = 16'(PREFETCH_X);
  localparam logic signed [15:0] SX_PRE_ACT = -16'sd1;
  localparam logic signed [15:0] SX_ACT     = 16'sd0;
  localparam logic [ADDR_W-1:0]  BASE       = ADDR_W'(FB_BASE);
  localparam logic [ADDR_W-1:0]  LINE_STEP  = ADDR_W'(SRC_W);
  localparam logic [WW-1:0]      LAST_WORD  = WW'(SRC_W - 1);

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_e;

  state_e              state_q, state_d;
  logic [WW-1:0]       word_q, word_d;
  logic                fill_bank_q, fill_bank_d;
  logic                ready_bank_q, ready_bank_d;
  logic [ADDR_W-1:0]   line_addr_q, line_addr_d;
  logic                last_rd_q, last_rd_d;
  logic                underrun_q, underrun_d;
  logic                disp_bank_q, disp_bank_d;
  logic                disp_valid_q, disp_valid_d;
  logic                wr_ack_q, wr_ack_d;
  logic                ram_en_q, ram_en_d;
  logic                ram_we_q, ram_we_d;
  logic [ADDR_W-1:0]   ram_addr_q, ram_addr_d;
  logic [DATA_W-1:0]   ram_wdata_q, ram_wdata_d;
  logic [WW:0]         rd_tag_q, rd_tag_d;
  logic                lb_we_q, lb_we_d;
  logic [WW:0]         lb_addr_q, lb_addr_d;

  logic signed [16:0]  sy_ext, tgt;
  logic                tgt_ok, cur_ok, trig;
  logic                wr_grant, rd_grant;

  assign sy_ext = 17'(i_sy);
  assign tgt    = sy_ext + 17'sd1;
  assign tgt_ok = (tgt >= LINE_LO) && (tgt < LINE_HI);
  assign cur_ok = (sy_ext >= LINE_LO) && (sy_ext < LINE_HI);
  assign trig   = (i_sx == TRIG_X) && tgt_ok;

  always_comb begin
    state_d      = state_q;
    word_d       = word_q;
    fill_bank_d  = fill_bank_q;
    ready_bank_d = ready_bank_q;
    line_addr_d  = line_addr_q;
    last_rd_d    = last_rd_q;
    underrun_d   = underrun_q;
    disp_bank_d  = disp_bank_q;
    disp_valid_d = disp_valid_q;
    wr_ack_d     = 1'b0;
    ram_en_d     = 1'b0;
    ram_we_d     = 1'b0;
    ram_addr_d   = ram_addr_q;
    ram_wdata_d  = ram_wdata_q;
    rd_tag_d     = rd_tag_q;
    lb_we_d      = ram_en_q && !ram_we_q;
    lb_addr_d    = rd_tag_q;
    wr_grant     = 1'b0;
    rd_grant     = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        wr_grant = i_wr_req;
        if (trig) begin
          state_d = S_FETCH;
          word_d  = '0;
        end
      end
      S_FETCH: begin
        if (i_wr_req && last_rd_q) wr_grant = 1'b1;
        else                       rd_grant = 1'b1;
        if (trig) underrun_d = 1'b1;
        if (rd_grant) begin
          word_d = word_q + WW'(1);
          if (word_q == LAST_WORD) state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        wr_grant = i_wr_req;
        if (trig) underrun_d = 1'b1;
        // Finished bank is staged here and only shown at the next pre-active-video tick,
        // so the line currently on screen keeps its bank until its own active video ends.
        ready_bank_d = fill_bank_q;
        fill_bank_d  = ~fill_bank_q;
        line_addr_d  = line_addr_q + LINE_STEP;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (wr_grant) begin
      ram_en_d    = 1'b1;
      ram_we_d    = 1'b1;
      wr_ack_d    = 1'b1;
      ram_addr_d  = i_wr_addr;
      ram_wdata_d = i_wr_data;
      last_rd_d   = 1'b0;
    end else if (rd_grant) begin
      ram_en_d   = 1'b1;
      ram_addr_d = line_addr_q + ADDR_W'(word_q);
      rd_tag_d   = {fill_bank_q, word_q};
      last_rd_d  = 1'b1;
    end

    if (i_sx == SX_ACT && tgt_ok && state_q != S_IDLE) underrun_d = 1'b1;

    if (i_sx == SX_PRE_ACT) begin
      disp_valid_d = cur_ok;
      disp_bank_d  = ready_bank_q;
    end

    if (i_frame) begin
      line_addr_d = BASE;
      underrun_d  = 1'b0;
    end
  end

  always_ff @(posedge i_pix_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      word_q       <= '0;
      fill_bank_q  <= 1'b0;
      ready_bank_q <= 1'b0;
      line_addr_q  <= BASE;
      last_rd_q    <= 1'b0;
      underrun_q   <= 1'b0;
      disp_bank_q  <= 1'b0;
      disp_valid_q <= 1'b0;
      wr_ack_q     <= 1'b0;
      ram_en_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_wdata_q  <= '0;
      rd_tag_q     <= '0;
      lb_we_q      <= 1'b0;
      lb_addr_q    <= '0;
    end else begin
      state_q      <= state_d;
      word_q       <= word_d;
      fill_bank_q  <= fill_bank_d;
      ready_bank_q <= ready_bank_d;
      line_addr_q  <= line_addr_d;
      last_rd_q    <= last_rd_d;
      underrun_q   <= underrun_d;
      disp_bank_q  <= disp_bank_d;
      disp_valid_q <= disp_valid_d;
      wr_ack_q     <= wr_ack_d;
      ram_en_q     <= ram_en_d;
      ram_we_q     <= ram_we_d;
      ram_addr_q   <= ram_addr_d;
      ram_wdata_q  <= ram_wdata_d;
      rd_tag_q     <= rd_tag_d;
      lb_we_q      <= lb_we_d;
      lb_addr_q    <= lb_addr_d;
    end
  end

  assign o_wr_ack     = wr_ack_q;
  assign o_ram_en     = ram_en_q;
  assign o_ram_we     = ram_we_q;
  assign o_ram_addr   = ram_addr_q;
  assign o_ram_wdata  = ram_wdata_q;
  assign o_lb_we      = lb_we_q;
  assign o_lb_addr    = lb_addr_q;
  assign o_lb_data    = lb_we_q ? i_ram_rdata : '0;
  assign o_disp_bank  = disp_bank_q;
  assign o_disp_valid = disp_valid_q;
  assign o_underrun   = underrun_q;

endmodule

// File: tb/tb_fb_line_prefetch_arbiter.sv
// Scoreboard bench: stimulus pushes expected RAM writes/reads and line-buffer writes,
// a negedge monitor pops and compares them as the DUT presents them.
module tb_fb_line_prefetch_arbiter;
  localparam int DATA_W = 16, ADDR_W = 15, SRC_W = 32, SRC_H = 342, V_OFF = 69;
  localparam int PREFETCH_X = -150;

  logic clk = 1'b0, rst = 1'b1;
  logic signed [15:0] sx = 16'sd30, sy = 16'sd0;
  logic i_frame = 1'b0, i_wr_req = 1'b0;
  logic [ADDR_W-1:0] i_wr_addr = '0;
  logic [DATA_W-1:0] i_wr_data = '0, ram_rdata = '0;
  logic o_wr_ack, o_ram_en, o_ram_we, o_lb_we, o_disp_bank, o_disp_valid, o_underrun;
  logic [ADDR_W-1:0] o_ram_addr;
  logic [DATA_W-1:0] o_ram_wdata, o_lb_data;
  logic [5:0] o_lb_addr;

  always #5 clk = ~clk;

  fb_line_prefetch_arbiter #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .V_OFF(V_OFF), .PREFETCH_X(PREFETCH_X), .FB_BASE(0)
  ) dut (
    .i_pix_clk(clk), .i_rst(rst), .i_sx(sx), .i_sy(sy), .i_frame(i_frame),
    .i_wr_req(i_wr_req), .i_wr_addr(i_wr_addr), .i_wr_data(i_wr_data),
    .o_wr_ack(o_wr_ack), .o_ram_en(o_ram_en), .o_ram_we(o_ram_we),
    .o_ram_addr(o_ram_addr), .o_ram_wdata(o_ram_wdata), .i_ram_rdata(ram_rdata),
    .o_lb_we(o_lb_we), .o_lb_addr(o_lb_addr), .o_lb_data(o_lb_data),
    .o_disp_bank(o_disp_bank), .o_disp_valid(o_disp_valid), .o_underrun(o_underrun)
  );

  function automatic logic [15:0] pat(input logic [14:0] a);
    return 16'(32'(a) * 7 + 32'h1234);
  endfunction

  // RAM model: read data appears the cycle after the read is presented
  always @(posedge clk) if (o_ram_en && !o_ram_we) ram_rdata <= pat(o_ram_addr);

  typedef struct packed { logic [14:0] a; logic [15:0] d; } wr_t;
  typedef struct packed { logic [14:0] a; logic [4:0] w; logic [1:0] gap; } rd_t;
  typedef struct packed { logic [5:0] la; logic [15:0] d; } lb_t;
  wr_t wq[$];
  rd_t rq[$];
  lb_t lq[$];

  int n_chk = 0, n_pass = 0;
  int wr_mode = 0;  // 0 none, 1 random, 2 saturating

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  task automatic fail_unexp(input string name, input logic [63:0] act);
    n_chk++;
    $display("FAIL %s: actual=%0h required=nothing pending", name, act);
  endtask

  // Monitor
  int mcyc = 0, last_rd = 0;
  initial begin
    forever begin
      @(negedge clk);
      mcyc++;
      if (o_ram_en && o_ram_we) begin
        if (wq.size() == 0) fail_unexp("unexpected_write", 64'(o_ram_addr));
        else begin
          wr_t w;
          w = wq.pop_front();
          chk("wr_addr", 64'(o_ram_addr), 64'(w.a));
          chk("wr_data", 64'(o_ram_wdata), 64'(w.d));
          chk("wr_ack", 64'(o_wr_ack), 64'd1);
        end
      end else if (o_ram_en) begin
        if (rq.size() == 0) fail_unexp("unexpected_read", 64'(o_ram_addr));
        else begin
          rd_t r;
          r = rq.pop_front();
          chk("rd_addr", 64'(o_ram_addr), 64'(r.a));
          if (r.w != 0 && r.gap != 0) chk("rd_spacing", 64'(mcyc - last_rd), 64'(r.gap));
        end
        last_rd = mcyc;
      end
      if (o_wr_ack && !(o_ram_en && o_ram_we)) fail_unexp("ack_without_write", 64'(o_wr_ack));
      if (o_lb_we) begin
        if (lq.size() == 0) fail_unexp("unexpected_lb_write", 64'(o_lb_addr));
        else begin
          lb_t l;
          l = lq.pop_front();
          chk("lb_addr", 64'(o_lb_addr), 64'(l.la));
          chk("lb_data", 64'(o_lb_data), 64'(l.d));
        end
      end
    end
  end

  // Capture writer: holds each request until acked
  initial begin
    forever begin
      @(posedge clk); #2;
      if (rst) i_wr_req = 1'b0;
      else if (!i_wr_req || o_wr_ack) begin
        if (wr_mode == 2 || (wr_mode == 1 && $urandom_range(0, 2) == 0)) begin
          i_wr_addr = 15'($urandom);
          i_wr_data = 16'($urandom);
          wq.push_back({i_wr_addr, i_wr_data});
          i_wr_req = 1'b1;
        end else i_wr_req = 1'b0;
      end
    end
  end

  // Reference model of the line schedule
  int cyc = 0, last_trig = -1000;
  logic [14:0] la = '0;
  logic fill = 1'b0, last_bank = 1'b0, prev_bank = 1'b0, und_m = 1'b0;

  task automatic tick();
    @(posedge clk); #1;
    cyc++;
  endtask

  function automatic bit in_src(input int y);
    return (y >= V_OFF) && (y < V_OFF + SRC_H);
  endfunction

  task automatic drive_px(input int x, input int y);
    sx = 16'(x);
    sy = 16'(y);
    tick();
    if (x == PREFETCH_X && in_src(y + 1)) begin
      if (cyc - last_trig >= 70) begin
        logic [1:0] gap;
        gap = (wr_mode == 0) ? 2'd1 : (wr_mode == 2) ? 2'd2 : 2'd0;
        for (int w = 0; w < SRC_W; w++) begin
          logic [14:0] a;
          a = la + 15'(w);
          rq.push_back({a, 5'(w), gap});
          lq.push_back({fill, 5'(w), pat(a)});
        end
        la = la + 15'(SRC_W);
        prev_bank = last_bank;
        last_bank = fill;
        fill = ~fill;
        last_trig = cyc;
      end else und_m = 1'b1;
    end
    if (x == 0 && in_src(y + 1) && cyc - last_trig < 34) und_m = 1'b1;
    if (x == -1) begin
      chk("disp_valid", 64'(o_disp_valid), 64'(in_src(y)));
      chk("disp_bank", 64'(o_disp_bank), 64'((cyc - last_trig >= 66) ? last_bank : prev_bank));
    end
  endtask

  // kind 0: normal line; 1: blanking cut short after the trigger; 2: repeated trigger
  task automatic line(input int y, input int kind);
    for (int x = -160; x <= ((kind == 1) ? 140 : 20); x++) begin
      if (kind == 1 && x > -150 && x < -5) continue;
      drive_px(x, y);
      if (kind == 2 && x == -148) drive_px(-150, y);
    end
    chk("underrun", 64'(o_underrun), 64'(und_m));
  endtask

  task automatic frame();
    i_frame = 1'b1;
    drive_px(30, 0);
    i_frame = 1'b0;
    la = '0;
    und_m = 1'b0;
    chk("underrun_after_frame", 64'(o_underrun), 64'(und_m));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (i == 0) begin
        wq.delete(); rq.delete(); lq.delete();
      end
      chk("reset_outputs", {4'h0, o_wr_ack, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata, o_lb_we,
                            o_lb_addr, o_lb_data, o_disp_bank, o_disp_valid, o_underrun}, 64'd0);
    end
    la = '0; fill = 1'b0; last_bank = 1'b0; prev_bank = 1'b0; und_m = 1'b0; last_trig = -1000;
    rst = 1'b0;
  endtask

  initial begin
    do_reset();
    frame();
    wr_mode = 0;
    for (int y = 66; y <= 71; y++) line(y, 0);
    wr_mode = 2;
    line(72, 0); line(73, 0);
    wr_mode = 1;
    for (int y = 74; y <= 79; y++) line(y, 0);
    wr_mode = 2;
    line(100, 1);
    line(101, 0);
    frame();
    wr_mode = 1;
    line(102, 2);
    frame();
    wr_mode = 0;
    line(68, 0); line(69, 0);
    wr_mode = 1;
    for (int y = 408; y <= 412; y++) line(y, 0);
    // reset while a fetch is in flight
    for (int x = -160; x <= -140; x++) drive_px(x, 80);
    do_reset();
    for (int i = 0; i < 20; i++) drive_px(30, 0);
    wr_mode = 0;
    line(68, 0); line(69, 0);
    for (int i = 0; i < 80; i++) drive_px(30, 0);
    chk("wr_queue_drained", 64'(wq.size()), 64'd0);
    chk("rd_queue_drained", 64'(rq.size()), 64'd0);
    chk("lb_queue_drained", 64'(lq.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
